udp_txbuf_reader: RTL and testbench
===================================

UDP_TXBUF_READER -- requirements
Module: udp_txbuf_reader

Interface
REQ-001 SHALL have parameter AWIDTH, default 6: UDP TX buffer word-address width.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port txbuf_rel  in  1  application pulse: buffer filled, ownership handed to reader.
REQ-005 SHALL have port txbuf_grant  out  1  1 = application owns buffer and may write it.
REQ-006 SHALL have port txbuf_addr  out  AWIDTH  buffer word address.
REQ-007 SHALL have port txbuf_ce  out  1  read enable.
REQ-008 SHALL have port txbuf_rdata  in  32  read data, valid exactly one cycle after the cycle with txbuf_ce=1.
REQ-009 SHALL have port hdr_valid  out  1, hdr_ready  in  1  header handshake.
REQ-010 SHALL have port hdr_dst_ip  out  32, hdr_src_port  out  16, hdr_dst_port  out  16, hdr_len  out  16.
REQ-011 SHALL have port pl_data  out  8, pl_valid  out  1, pl_ready  in  1, pl_last  out  1  payload byte stream.
REQ-012 SHALL have port len_err  out  1  one-cycle pulse on an oversize length.

Function
REQ-013 Buffer layout SHALL be: word0 = destination IP (bits[7:0] = first octet); word1 = {src_port[31:16], dst_port[15:0]}; word2[15:0] = payload length in bytes; word3 onward = payload, bytes ordered LSB first.
REQ-014 MAXLEN SHALL be (2^AWIDTH-3)*4 (244 at default).
REQ-015 States SHALL be IDLE, RD_IP, RD_PORT, RD_LEN, HDR, PAYLOAD, DONE.
REQ-016 IDLE: txbuf_grant=1; txbuf_rel=1 -> txbuf_grant=0 next cycle, enter RD_IP; txbuf_rel=0 -> stay in IDLE.
REQ-017 txbuf_rel SHALL be ignored in every state other than IDLE.
REQ-018 RD_IP/RD_PORT/RD_LEN SHALL each issue one read (ce=1, addr 0/1/2) and capture its data one cycle later; header fetch completes within 4 cycles of entering RD_IP.
REQ-019 After the length is captured: if len > MAXLEN, len_err SHALL pulse for one cycle, nothing SHALL be emitted, and the FSM SHALL go to DONE; otherwise the FSM SHALL go to HDR.
REQ-020 HDR: hdr_valid=1 with fields held stable until hdr_ready=1; transfer on valid&ready; then go to PAYLOAD if len>0, else DONE.
REQ-021 PAYLOAD: read word3, word4, ... in sequence; emit bytes LSB first; pl_last=1 on byte number len (1-based); the trailing bytes of the final word SHALL be discarded.
REQ-022 pl_data and pl_last SHALL hold stable while pl_valid=1 and pl_ready=0; a byte transfers on pl_valid&pl_ready.
REQ-023 Word prefetch: the next word SHALL be read no later than the transfer of the current word's byte 3, so that with pl_ready held at 1 the stream runs at one byte per cycle with no bubbles after the first byte.
REQ-024 txbuf_ce SHALL never be asserted while txbuf_grant=1, and no address >= 2^AWIDTH SHALL be issued.
REQ-025 DONE: txbuf_grant SHALL return to 1 next cycle, enter IDLE; a txbuf_rel in the same cycle as the grant rising SHALL be accepted as a new request.
REQ-026 hdr_len SHALL equal the captured word2[15:0]; the byte counter SHALL be 16 bits wide with no wrap.

Reset
REQ-027 While rst=1 at a rising edge: state IDLE, txbuf_grant=1, txbuf_ce=0, txbuf_addr=0, hdr_valid=0, pl_valid=0, pl_last=0, len_err=0, header and data registers 0.
REQ-028 rst mid-transfer SHALL abandon the packet with no further outputs; txbuf_grant=1 on the first cycle after reset deasserts.

Verification
REQ-029 Buffer {0x0a01a8c0, 0x045704d2, 15, "UDP Send Test\n"}, rel pulse, both readies held 1 -> header 192.168.1.10/1111/1234/15, then 15 bytes "UDP Send Test\n" plus NUL, no bubbles, pl_last on byte 15, grant returns to 1.
REQ-030 len=0 -> one header transfer, no pl_valid, grant returns to 1 after the header handshake.
REQ-031 len=245 (AWIDTH=6) -> len_err single pulse, no hdr_valid, no pl_valid, grant returns to 1; len=244 -> 244 bytes, final address 63.
REQ-032 Random pl_ready/hdr_ready stalls on a len=7 packet -> byte sequence identical to the no-stall run; outputs stable while stalled; ce never asserted with grant=1.
REQ-033 rst pulsed at payload byte 5 -> outputs cleared, grant=1; a following rel pulse -> full packet delivered correctly.
REQ-034 rel pulsed during PAYLOAD -> ignored; rel in the cycle grant rises -> second packet delivered back-to-back.

Source files
------------

// File: rtl/udp_txbuf_reader.sv
// UDP TX buffer reader: fetches a header and payload from a word buffer
// and streams it out as a header handshake plus a byte stream.
module udp_txbuf_reader #(
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txbuf_rel,
    output logic              txbuf_grant,
    output logic [AWIDTH-1:0] txbuf_addr,
    output logic              txbuf_ce,
    input  logic [31:0]       txbuf_rdata,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [31:0]       hdr_dst_ip,
    output logic [15:0]       hdr_src_port,
    output logic [15:0]       hdr_dst_port,
    output logic [15:0]       hdr_len,
    output logic [7:0]        pl_data,
    output logic              pl_valid,
    input  logic              pl_ready,
    output logic              pl_last,
    output logic              len_err
);

    localparam int MAXLEN = ((1 << AWIDTH) - 3) * 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_IP,
        RD_PORT,
        RD_LEN,
        HDR,
        PAYLOAD,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic   ph_q, ph_d;

    logic              rd_pend_q;
    logic              cur_vld_q;
    logic              nxt_vld_q;
    logic [31:0]       cur_q;
    logic [31:0]       nxt_q;
    logic [1:0]        bsel_q;
    logic [15:0]       cnt_q;
    logic [15:0]       words_q;
    logic [AWIDTH-1:0] rd_addr_q;

    logic        issue;
    logic        beat;
    logic        take;
    logic        len_big;
    logic [15:0] len_in;
    logic [15:0] words_in;

    assign len_in   = txbuf_rdata[15:0];
    assign len_big  = {1'b0, len_in} > 17'(MAXLEN);
    assign words_in = 16'((17'(len_in) + 17'd3) >> 2);

    assign txbuf_grant = (state_q == IDLE);
    assign hdr_valid   = (state_q == HDR);
    assign pl_valid    = (state_q == PAYLOAD) && cur_vld_q;
    assign pl_last     = pl_valid && ((cnt_q + 16'd1) == hdr_len);
    assign pl_data     = cur_q[{bsel_q, 3'b000} +: 8];
    assign beat        = pl_valid && pl_ready;
    assign take        = beat && ((bsel_q == 2'd3) || pl_last);

    // State register; the phase bit splits RD_LEN into issue and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    // Next-state logic and buffer read requests.
    always_comb begin
        state_d    = state_q;
        ph_d       = 1'b0;
        txbuf_ce   = 1'b0;
        txbuf_addr = '0;
        issue      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (txbuf_rel) state_d = RD_IP;
            end
            RD_IP: begin
                txbuf_ce   = 1'b1;
                txbuf_addr = AWIDTH'(0);
                state_d    = RD_PORT;
            end
            RD_PORT: begin
                txbuf_ce   = 1'b1;
                txbuf_addr = AWIDTH'(1);
                state_d    = RD_LEN;
            end
            RD_LEN: begin
                if (!ph_q) begin
                    txbuf_ce   = 1'b1;
                    txbuf_addr = AWIDTH'(2);
                    ph_d       = 1'b1;
                end else if (len_big) begin
                    state_d = DONE;
                end else begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (hdr_ready)
                    state_d = (hdr_len == 16'd0) ? DONE : PAYLOAD;
            end
            PAYLOAD: begin
                issue = (words_q != 16'd0) && !rd_pend_q && !nxt_vld_q;
                if (issue) begin
                    txbuf_ce   = 1'b1;
                    txbuf_addr = rd_addr_q;
                end
                if (beat && pl_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Header field capture and the oversize-length pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_dst_ip   <= '0;
            hdr_src_port <= '0;
            hdr_dst_port <= '0;
            hdr_len      <= '0;
            len_err      <= 1'b0;
        end else begin
            len_err <= (state_q == RD_LEN) && ph_q && len_big;
            if (state_q == RD_PORT)
                hdr_dst_ip <= txbuf_rdata;
            if (state_q == RD_LEN && !ph_q) begin
                hdr_src_port <= txbuf_rdata[31:16];
                hdr_dst_port <= txbuf_rdata[15:0];
            end
            if (state_q == RD_LEN && ph_q)
                hdr_len <= len_in;
        end
    end

    // Payload word pipeline: current word being emitted plus one prefetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            cur_vld_q <= 1'b0;
            nxt_vld_q <= 1'b0;
            cur_q     <= '0;
            nxt_q     <= '0;
            bsel_q    <= '0;
            cnt_q     <= '0;
            words_q   <= '0;
            rd_addr_q <= '0;
        end else if (state_q == RD_LEN && ph_q) begin
            rd_pend_q <= 1'b0;
            cur_vld_q <= 1'b0;
            nxt_vld_q <= 1'b0;
            bsel_q    <= '0;
            cnt_q     <= '0;
            words_q   <= words_in;
            rd_addr_q <= AWIDTH'(3);
        end else if (state_q == PAYLOAD) begin
            rd_pend_q <= issue;
            if (issue) begin
                rd_addr_q <= rd_addr_q + AWIDTH'(1);
                words_q   <= words_q - 16'd1;
            end
            if (beat) begin
                cnt_q  <= cnt_q + 16'd1;
                bsel_q <= bsel_q + 2'd1;
            end
            if (take) bsel_q <= '0;
            if (!cur_vld_q || take) begin
                cur_vld_q <= nxt_vld_q || rd_pend_q;
                if (nxt_vld_q)
                    cur_q <= nxt_q;
                else if (rd_pend_q)
                    cur_q <= txbuf_rdata;
                nxt_vld_q <= 1'b0;
            end else if (rd_pend_q) begin
                nxt_q     <= txbuf_rdata;
                nxt_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udp_txbuf_reader.sv
// Directed bench for udp_txbuf_reader: buffer model, header and byte
// stream capture, stall/reset/back-to-back scenarios.
module tb_udp_txbuf_reader;

    logic        clk;
    logic        rst;
    logic        txbuf_rel;
    logic        txbuf_grant;
    logic [5:0]  txbuf_addr;
    logic        txbuf_ce;
    logic [31:0] txbuf_rdata;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] hdr_dst_ip;
    logic [15:0] hdr_src_port;
    logic [15:0] hdr_dst_port;
    logic [15:0] hdr_len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        pl_last;
    logic        len_err;

    udp_txbuf_reader #(.AWIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .txbuf_rel    (txbuf_rel),
        .txbuf_grant  (txbuf_grant),
        .txbuf_addr   (txbuf_addr),
        .txbuf_ce     (txbuf_ce),
        .txbuf_rdata  (txbuf_rdata),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_dst_ip   (hdr_dst_ip),
        .hdr_src_port (hdr_src_port),
        .hdr_dst_port (hdr_dst_port),
        .hdr_len      (hdr_len),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .pl_last      (pl_last),
        .len_err      (len_err)
    );

    logic [31:0] mem [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial txbuf_rdata = '0;
    always @(posedge clk) begin
        if (txbuf_ce) txbuf_rdata <= mem[txbuf_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] rx[$];
    logic [7:0] ref_rx[$];
    int hdr_cnt, hdr_vcyc, plv_cyc, err_cnt, last_idx;
    int first_cyc, last_cyc, ce_viol, stab_viol, max_addr;
    bit finished;
    logic [31:0] cap_ip;
    logic [15:0] cap_src, cap_dst, cap_len;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_hdr(input logic [15:0] len);
        mem[0] = 32'h0a01a8c0;
        mem[1] = 32'h045704d2;
        mem[2] = {16'h0, len};
    endtask

    task automatic load_test_pkt();
        load_hdr(16'd15);
        mem[3] = 32'h20504455;
        mem[4] = 32'h646e6553;
        mem[5] = 32'h73655420;
        mem[6] = 32'h00000a74;
    endtask

    task automatic start_pkt();
        txbuf_rel = 1'b1;
        @(negedge clk);
        txbuf_rel = 1'b0;
    endtask

    task automatic collect(input bit stall, input int rel_byte,
                           input int rst_byte, input bit rel_on_done);
        bit       ps_pl, ps_hdr, rel_done;
        logic [7:0] p_data;
        logic     p_last;
        rx.delete();
        hdr_cnt = 0; hdr_vcyc = 0; plv_cyc = 0; err_cnt = 0;
        last_idx = 0; first_cyc = -1; last_cyc = -1;
        ce_viol = 0; stab_viol = 0; max_addr = 0;
        finished = 0; ps_pl = 0; ps_hdr = 0; rel_done = 0;
        p_data = '0; p_last = 0;
        for (int c = 0; c < 3000; c++) begin
            txbuf_rel = 1'b0;
            if (txbuf_ce && txbuf_grant) ce_viol++;
            if (txbuf_grant) begin
                finished = 1;
                if (rel_on_done) begin
                    txbuf_rel = 1'b1;
                    @(negedge clk);
                    txbuf_rel = 1'b0;
                end
                break;
            end
            if (stall) begin
                hdr_ready = 1'($urandom_range(0, 1));
                pl_ready  = 1'($urandom_range(0, 1));
            end else begin
                hdr_ready = 1'b1;
                pl_ready  = 1'b1;
            end
            if (txbuf_ce && int'(txbuf_addr) > max_addr)
                max_addr = int'(txbuf_addr);
            if (ps_pl && !(pl_valid && pl_data === p_data
                           && pl_last === p_last))
                stab_viol++;
            if (ps_hdr && !hdr_valid) stab_viol++;
            if (hdr_valid) hdr_vcyc++;
            if (pl_valid) plv_cyc++;
            if (len_err) err_cnt++;
            if (hdr_valid && hdr_ready) begin
                hdr_cnt++;
                cap_ip  = hdr_dst_ip;
                cap_src = hdr_src_port;
                cap_dst = hdr_dst_port;
                cap_len = hdr_len;
            end
            if (pl_valid && pl_ready) begin
                rx.push_back(pl_data);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                if (pl_last) last_idx = rx.size();
            end
            ps_pl  = pl_valid && !pl_ready;
            ps_hdr = hdr_valid && !hdr_ready;
            p_data = pl_data;
            p_last = pl_last;
            if (rel_byte >= 0 && rx.size() == rel_byte && !rel_done) begin
                txbuf_rel = 1'b1;
                rel_done  = 1;
            end
            if (rst_byte >= 0 && rx.size() == rst_byte) begin
                rst = 1'b1;
                @(negedge clk);
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        txbuf_rel = 1'b0;
        hdr_ready = 1'b1;
        pl_ready  = 1'b1;
    endtask

    task automatic check_test_pkt(input string p);
        string s;
        int bad;
        logic [7:0] e;
        s = "UDP Send Test\n";
        bad = 0;
        chk({p, "_done"}, 32'(finished), 32'd1);
        chk({p, "_hdrs"}, hdr_cnt, 32'd1);
        chk({p, "_ip"}, cap_ip, 32'h0a01a8c0);
        chk({p, "_src"}, 32'(cap_src), 32'd1111);
        chk({p, "_dst"}, 32'(cap_dst), 32'd1234);
        chk({p, "_len"}, 32'(cap_len), 32'd15);
        chk({p, "_nbytes"}, rx.size(), 32'd15);
        for (int i = 0; i < 15; i++) begin
            e = (i < 14) ? s[i] : 8'h00;
            if (i >= rx.size() || rx[i] !== e) bad++;
        end
        chk({p, "_bytes"}, bad, 32'd0);
        chk({p, "_last"}, last_idx, 32'd15);
        chk({p, "_err"}, err_cnt, 32'd0);
        chk({p, "_cegrant"}, ce_viol, 32'd0);
    endtask

    initial begin
        int bad;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b1;
        txbuf_rel = 1'b0;
        hdr_ready = 1'b1;
        pl_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_grant", 32'(txbuf_grant), 32'd1);
        chk("rst_ce", 32'(txbuf_ce), 32'd0);
        chk("rst_addr", 32'(txbuf_addr), 32'd0);
        chk("rst_hdrv", 32'(hdr_valid), 32'd0);
        chk("rst_plv", 32'(pl_valid), 32'd0);
        chk("rst_last", 32'(pl_last), 32'd0);
        chk("rst_err", 32'(len_err), 32'd0);
        chk("rst_ip", hdr_dst_ip, 32'd0);
        chk("rst_len", 32'(hdr_len), 32'd0);
        chk("rst_data", 32'(pl_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load_test_pkt();
        start_pkt();
        collect(0, -1, -1, 0);
        check_test_pkt("basic");
        chk("basic_nobubble", last_cyc - first_cyc, 32'd14);

        load_hdr(16'd0);
        start_pkt();
        collect(0, -1, -1, 0);
        chk("len0_done", 32'(finished), 32'd1);
        chk("len0_hdrs", hdr_cnt, 32'd1);
        chk("len0_len", 32'(cap_len), 32'd0);
        chk("len0_plv", plv_cyc, 32'd0);

        load_hdr(16'd245);
        start_pkt();
        collect(0, -1, -1, 0);
        chk("big_done", 32'(finished), 32'd1);
        chk("big_err", err_cnt, 32'd1);
        chk("big_hdrv", hdr_vcyc, 32'd0);
        chk("big_plv", plv_cyc, 32'd0);

        load_hdr(16'd244);
        for (int w = 0; w < 61; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(4 * w + k) ^ 8'h5a;
                mem[3 + w][8 * k +: 8] = b;
            end
        end
        start_pkt();
        collect(0, -1, -1, 0);
        bad = 0;
        for (int i = 0; i < 244; i++) begin
            b = 8'(i) ^ 8'h5a;
            if (i >= rx.size() || rx[i] !== b) bad++;
        end
        chk("max_done", 32'(finished), 32'd1);
        chk("max_nbytes", rx.size(), 32'd244);
        chk("max_bytes", bad, 32'd0);
        chk("max_last", last_idx, 32'd244);
        chk("max_addr", max_addr, 32'd63);
        chk("max_nobubble", last_cyc - first_cyc, 32'd243);
        chk("max_err", err_cnt, 32'd0);

        load_hdr(16'd7);
        mem[3] = 32'h44332211;
        mem[4] = 32'h00776655;
        start_pkt();
        collect(0, -1, -1, 0);
        ref_rx = rx;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            b = 8'(8'h11 * (i + 1));
            if (i >= rx.size() || rx[i] !== b) bad++;
        end
        chk("s7_ref_n", rx.size(), 32'd7);
        chk("s7_ref_bytes", bad, 32'd0);
        chk("s7_ref_last", last_idx, 32'd7);
        for (int r = 0; r < 3; r++) begin
            start_pkt();
            collect(1, -1, -1, 0);
            chk("s7_done", 32'(finished), 32'd1);
            chk("s7_same", 32'(rx == ref_rx), 32'd1);
            chk("s7_last", last_idx, 32'd7);
            chk("s7_stable", stab_viol, 32'd0);
            chk("s7_cegrant", ce_viol, 32'd0);
        end

        load_test_pkt();
        start_pkt();
        collect(0, -1, 5, 0);
        chk("mrst_grant", 32'(txbuf_grant), 32'd1);
        chk("mrst_ce", 32'(txbuf_ce), 32'd0);
        chk("mrst_hdrv", 32'(hdr_valid), 32'd0);
        chk("mrst_plv", 32'(pl_valid), 32'd0);
        chk("mrst_last", 32'(pl_last), 32'd0);
        chk("mrst_ip", hdr_dst_ip, 32'd0);
        chk("mrst_len", 32'(hdr_len), 32'd0);
        chk("mrst_data", 32'(pl_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_grant_after", 32'(txbuf_grant), 32'd1);
        start_pkt();
        collect(0, -1, -1, 0);
        check_test_pkt("after_rst");

        start_pkt();
        collect(0, 2, -1, 0);
        check_test_pkt("relpl");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!txbuf_grant || txbuf_ce) bad++;
            @(negedge clk);
        end
        chk("relpl_idle", bad, 32'd0);

        start_pkt();
        collect(0, -1, -1, 1);
        check_test_pkt("b2b1");
        collect(0, -1, -1, 0);
        check_test_pkt("b2b2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
